// File: rtl/trap_sequencer_pkg.sv
// Shared types, CSR addresses and mstatus field positions for the trap sequencer.
// The two status helpers encode machine-mode trap entry and mret exit.
package trap_sequencer_pkg;

    typedef logic [31:0] word_t;
    typedef logic [11:0] csr_addr_t;

    localparam csr_addr_t ISA_CSR_ADDR_MSTATUS = 12'h300;
    localparam csr_addr_t ISA_CSR_ADDR_MTVEC   = 12'h305;
    localparam csr_addr_t ISA_CSR_ADDR_MEPC    = 12'h341;
    localparam csr_addr_t ISA_CSR_ADDR_MCAUSE  = 12'h342;

    localparam int MIE    = 3;
    localparam int MPIE   = 7;
    localparam int MPP_LO = 11;
    localparam int MPP_HI = 12;

    typedef enum logic [2:0] {
        IDLE,
        T_EPC,
        T_CAUSE,
        T_STATUS,
        T_VEC,
        M_STATUS,
        M_EPC
    } trap_state_t;

    function automatic word_t trapEntryStatus(input word_t ms);
        word_t r;
        r              = ms;
        r[MPIE]        = ms[MIE];
        r[MIE]         = 1'b0;
        r[MPP_HI:MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic word_t trapReturnStatus(input word_t ms);
        word_t r;
        r              = ms;
        r[MIE]         = ms[MPIE];
        r[MPIE]        = 1'b1;
        r[MPP_HI:MPP_LO] = 2'b00;
        return r;
    endfunction

endpackage

// File: rtl/trap_sequencer_target_calc.sv
// Trap handler target from mtvec and cause; vectored interrupt dispatch is
// only present when TRAP_SEQUENCER_VECTORED_EN is defined.
module trap_target_calc
    import trap_sequencer_pkg::*;
(
    input  logic [31:0] mtvec_i,
    input  logic [31:0] cause_i,
    output logic [31:0] target_o
);

    word_t base;
    assign base = {mtvec_i[31:2], 2'b00};

`ifdef TRAP_SEQUENCER_VECTORED_EN
    // Interrupt offsets wrap modulo 2^32, so cause bit 30 falls off the top.
    logic unusedCauseBit;
    assign unusedCauseBit = cause_i[30];

    always_comb begin
        target_o = base;
        if (mtvec_i[1:0] == 2'b01 && cause_i[31]) begin
            target_o = base + {cause_i[29:0], 2'b00};
        end
    end
`else
    logic unusedDirectBits;
    assign unusedDirectBits = ^{cause_i, mtvec_i[1:0]};

    assign target_o = base;
`endif

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / mret sequencer that walks the CSR file one access per cycle.
// Vectored interrupt targets depend on TRAP_SEQUENCER_VECTORED_EN (see trap_target_calc).
module trap_sequencer
    import trap_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret_req,
    output logic        ack,
    output logic [31:0] redirect_pc,
    output logic        busy,
    output logic        csr_write_en,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata,
    input  logic [31:0] mstatus
);

    trap_state_t state_q;
    logic [31:2] capPc_q;
    word_t       capCause_q;
    logic        csrWe_q;
    csr_addr_t   csrAddr_q;
    logic        ack_q;
    logic        busy_q;
    word_t       vecTarget;

    logic unusedPcBits;
    assign unusedPcBits = ^trap_pc[1:0];

    // Strobe, address, ack and busy are registered alongside the state so the
    // CSR port never sees a combinational path from the request lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            capPc_q    <= '0;
            capCause_q <= '0;
            csrWe_q    <= 1'b0;
            csrAddr_q  <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trap_req) begin
                        state_q    <= T_EPC;
                        capPc_q    <= trap_pc[31:2];
                        capCause_q <= trap_cause;
                        csrWe_q    <= 1'b1;
                        csrAddr_q  <= ISA_CSR_ADDR_MEPC;
                        busy_q     <= 1'b1;
                    end else if (mret_req) begin
                        state_q    <= M_STATUS;
                        csrWe_q    <= 1'b1;
                        csrAddr_q  <= ISA_CSR_ADDR_MSTATUS;
                        busy_q     <= 1'b1;
                    end
                end
                T_EPC: begin
                    state_q   <= T_CAUSE;
                    csrWe_q   <= 1'b1;
                    csrAddr_q <= ISA_CSR_ADDR_MCAUSE;
                end
                T_CAUSE: begin
                    state_q   <= T_STATUS;
                    csrWe_q   <= 1'b1;
                    csrAddr_q <= ISA_CSR_ADDR_MSTATUS;
                end
                T_STATUS: begin
                    state_q   <= T_VEC;
                    csrWe_q   <= 1'b0;
                    csrAddr_q <= ISA_CSR_ADDR_MTVEC;
                    ack_q     <= 1'b1;
                end
                M_STATUS: begin
                    state_q   <= M_EPC;
                    csrWe_q   <= 1'b0;
                    csrAddr_q <= ISA_CSR_ADDR_MEPC;
                    ack_q     <= 1'b1;
                end
                T_VEC, M_EPC: begin
                    state_q   <= IDLE;
                    csrWe_q   <= 1'b0;
                    csrAddr_q <= '0;
                    ack_q     <= 1'b0;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    csrWe_q   <= 1'b0;
                    csrAddr_q <= '0;
                    ack_q     <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    // Status writes modify the live mstatus so bits owned elsewhere pass through.
    always_comb begin
        csr_wdata = '0;
        case (state_q)
            T_EPC:    csr_wdata = {capPc_q, 2'b00};
            T_CAUSE:  csr_wdata = capCause_q;
            T_STATUS: csr_wdata = trapEntryStatus(mstatus);
            M_STATUS: csr_wdata = trapReturnStatus(mstatus);
            default:  csr_wdata = '0;
        endcase
    end

    trap_target_calc u_target (
        .mtvec_i  (csr_rdata),
        .cause_i  (capCause_q),
        .target_o (vecTarget)
    );

    always_comb begin
        redirect_pc = '0;
        case (state_q)
            T_VEC:   redirect_pc = vecTarget;
            M_EPC:   redirect_pc = csr_rdata;
            default: redirect_pc = '0;
        endcase
    end

    assign ack          = ack_q;
    assign busy         = busy_q;
    assign csr_write_en = csrWe_q;
    assign csr_addr     = csrAddr_q;

endmodule
